// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO with occupancy count,
// almost-full/almost-empty flags, synchronous flush and dropped-request pulses.
module sync_fifo #(
    parameter int DW       = 8,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic          clock,
    input  logic          preset_L,
    input  logic          clear,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          wr_ok, rd_ok;

    assign full         = count == (AW+1)'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= (AW+1)'(AF_LEVEL);
    assign almost_empty = count <= (AW+1)'(AE_LEVEL);
    assign rdata        = empty ? '0 : mem[rptr];
    // A read at full frees the slot this edge, so the write may proceed.
    assign wr_ok        = we && (!full || re);
    assign rd_ok        = re && !empty;

    always_ff @(posedge clock or negedge preset_L) begin
        if (!preset_L) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr      <= wptr + AW'(wr_ok);
            rptr      <= rptr + AW'(rd_ok);
            count     <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
            overflow  <= we && !wr_ok;
            underflow <= re && !rd_ok;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_ok && !clear) mem[wptr] <= wdata;
    end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo (DW=8, DEPTH=16).
module tb_sync_fifo;
    logic       clock = 1'b0;
    logic       preset_L = 1'b0;
    logic       clear = 1'b0;
    logic       we = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       re = 1'b0;
    logic [7:0] rdata;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;
    int         passed = 0;
    int         total = 0;

    sync_fifo #(.DW(8), .DEPTH(16)) dut (
        .clock(clock), .preset_L(preset_L), .clear(clear), .we(we), .wdata(wdata),
        .re(re), .rdata(rdata), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #12 preset_L = 1'b1;
        step();
        total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else passed++;
        total++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else passed++;
        total++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
        total++; if (rdata !== 8'h00) $display("FAIL reset_rdata got %h exp 00", rdata); else passed++;
        total++; if (almost_empty !== 1'b1) $display("FAIL reset_ae got %b exp 1", almost_empty); else passed++;
        total++; if (almost_full !== 1'b0) $display("FAIL reset_af got %b exp 0", almost_full); else passed++;
        total++; if (overflow !== 1'b0 || underflow !== 1'b0)
            $display("FAIL reset_pulses got %b%b exp 00", overflow, underflow); else passed++;
        re = 1'b1;
        step();
        re = 1'b0;
        total++; if (underflow !== 1'b1) $display("FAIL idle_underflow got %b exp 1", underflow); else passed++;
        total++; if (count !== 5'd0) $display("FAIL idle_underflow_count got %0d exp 0", count); else passed++;
        step();
        total++; if (underflow !== 1'b0) $display("FAIL underflow_clear got %b exp 0", underflow); else passed++;
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 16; i++) begin
            we = 1'b1;
            wdata = 8'(i);
            step();
            total++; if (count !== 5'(i)) $display("FAIL fill_count got %0d exp %0d", count, i); else passed++;
            total++; if (almost_full !== (i >= 14)) $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, i >= 14); else passed++;
            total++; if (almost_empty !== (i <= 2)) $display("FAIL fill_ae[%0d] got %b exp %b", i, almost_empty, i <= 2); else passed++;
            total++; if (full !== (i == 16)) $display("FAIL fill_full[%0d] got %b exp %b", i, full, i == 16); else passed++;
            total++; if (rdata !== 8'h01) $display("FAIL fill_head got %h exp 01", rdata); else passed++;
        end
        wdata = 8'hFF;
        step();
        we = 1'b0;
        total++; if (overflow !== 1'b1) $display("FAIL overflow_pulse got %b exp 1", overflow); else passed++;
        total++; if (count !== 5'd16) $display("FAIL overflow_count got %0d exp 16", count); else passed++;
        step();
        total++; if (overflow !== 1'b0) $display("FAIL overflow_clear got %b exp 0", overflow); else passed++;
        for (int i = 1; i <= 16; i++) begin
            total++; if (rdata !== 8'(i)) $display("FAIL drain_data got %h exp %h", rdata, 8'(i)); else passed++;
            re = 1'b1;
            step();
        end
        re = 1'b0;
        total++; if (empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", empty); else passed++;
        total++; if (rdata !== 8'h00) $display("FAIL drain_rdata got %h exp 00", rdata); else passed++;
        total++; if (underflow !== 1'b0) $display("FAIL drain_underflow got %b exp 0", underflow); else passed++;
    endtask

    task automatic test_full_streaming();
        for (int i = 0; i < 16; i++) begin
            we = 1'b1;
            wdata = 8'(8'h20 + i);
            step();
        end
        for (int c = 0; c < 40; c++) begin
            total++; if (rdata !== 8'(8'h20 + c)) $display("FAIL stream_data got %h exp %h", rdata, 8'(8'h20 + c)); else passed++;
            we = 1'b1;
            re = 1'b1;
            wdata = 8'(8'h30 + c);
            step();
            total++; if (count !== 5'd16) $display("FAIL stream_count got %0d exp 16", count); else passed++;
            total++; if (overflow !== 1'b0) $display("FAIL stream_overflow got %b exp 0", overflow); else passed++;
        end
        we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++; if (rdata !== 8'(8'h48 + i)) $display("FAIL stream_drain got %h exp %h", rdata, 8'(8'h48 + i)); else passed++;
            step();
        end
        re = 1'b0;
        total++; if (empty !== 1'b1) $display("FAIL stream_empty got %b exp 1", empty); else passed++;
    endtask

    task automatic test_empty_rw();
        we = 1'b1;
        re = 1'b1;
        wdata = 8'hA5;
        step();
        we = 1'b0;
        re = 1'b0;
        total++; if (underflow !== 1'b1) $display("FAIL erw_underflow got %b exp 1", underflow); else passed++;
        total++; if (count !== 5'd1) $display("FAIL erw_count got %0d exp 1", count); else passed++;
        total++; if (rdata !== 8'hA5) $display("FAIL erw_rdata got %h exp a5", rdata); else passed++;
        step();
        total++; if (underflow !== 1'b0) $display("FAIL erw_underflow_clear got %b exp 0", underflow); else passed++;
        re = 1'b1;
        step();
        re = 1'b0;
        total++; if (empty !== 1'b1) $display("FAIL erw_empty got %b exp 1", empty); else passed++;
    endtask

    task automatic test_clear();
        for (int i = 0; i < 9; i++) begin
            we = 1'b1;
            wdata = 8'(8'h50 + i);
            step();
        end
        total++; if (count !== 5'd9) $display("FAIL clr_fill_count got %0d exp 9", count); else passed++;
        clear = 1'b1;
        wdata = 8'h77;
        step();
        clear = 1'b0;
        we = 1'b0;
        total++; if (count !== 5'd0) $display("FAIL clr_count got %0d exp 0", count); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL clr_empty got %b exp 1", empty); else passed++;
        total++; if (rdata !== 8'h00) $display("FAIL clr_rdata got %h exp 00", rdata); else passed++;
        total++; if (overflow !== 1'b0 || underflow !== 1'b0)
            $display("FAIL clr_pulses got %b%b exp 00", overflow, underflow); else passed++;
        we = 1'b1;
        wdata = 8'h3C;
        step();
        we = 1'b0;
        total++; if (rdata !== 8'h3C) $display("FAIL clr_next_rdata got %h exp 3c", rdata); else passed++;
        total++; if (count !== 5'd1) $display("FAIL clr_next_count got %0d exp 1", count); else passed++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) begin
            we = 1'b1;
            wdata = 8'(8'h60 + i);
            step();
        end
        total++; if (count !== 5'd7) $display("FAIL ar_pre_count got %0d exp 7", count); else passed++;
        #2 preset_L = 1'b0;
        #1;
        total++; if (count !== 5'd0) $display("FAIL ar_count got %0d exp 0", count); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL ar_empty got %b exp 1", empty); else passed++;
        total++; if (rdata !== 8'h00) $display("FAIL ar_rdata got %h exp 00", rdata); else passed++;
        total++; if (almost_empty !== 1'b1 || almost_full !== 1'b0 || full !== 1'b0)
            $display("FAIL ar_flags got %b%b%b exp 100", almost_empty, almost_full, full); else passed++;
        we = 1'b0;
        @(negedge clock);
        preset_L = 1'b1;
        we = 1'b1;
        wdata = 8'hC3;
        step();
        we = 1'b0;
        total++; if (rdata !== 8'hC3) $display("FAIL ar_post_rdata got %h exp c3", rdata); else passed++;
        total++; if (count !== 5'd1) $display("FAIL ar_post_count got %0d exp 1", count); else passed++;
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_full_streaming();
        test_empty_rw();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
